// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM states and the default operand width.
package mult_div_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } mdOp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } mdState_e;

endpackage

// File: rtl/mult_div_unit_core.sv
// Datapath of the multiply/divide unit: operand magnitudes, the 2*WIDTH
// accumulator/remainder shift register and the final sign correction.
module mult_div_unit_core
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opA_i,
  input  logic [WIDTH-1:0] opB_i,
  output logic             divZero_o,
  output logic [WIDTH-1:0] resHi_o,
  output logic [WIDTH-1:0] resLo_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               isDiv_q, negLo_q, negHi_q;

  logic               isDiv, isSigned, negRes, negRem;
  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH:0]     sum, rem;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod;

  assign isDiv     = op_i[1] & ~op_i[2];
  assign isSigned  = ~op_i[0];
  assign magA      = (isSigned && opA_i[WIDTH-1]) ? -opA_i : opA_i;
  assign magB      = (isSigned && opB_i[WIDTH-1]) ? -opB_i : opB_i;
  assign negRes    = isSigned & (opA_i[WIDTH-1] ^ opB_i[WIDTH-1]);
  assign negRem    = isSigned & opA_i[WIDTH-1];
  assign divZero_o = isDiv && (opB_i == '0);

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    acc_d = acc_q;
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem   = acc_q[2*WIDTH-1:WIDTH-1];
    diff  = rem[WIDTH-1:0] - opnd_q;
    if (isDiv_q) begin
      if (rem >= {1'b0, opnd_q}) acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
      else                       acc_d = {rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  // A zero divisor preloads the defined result so the FIX state needs no special case.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q   <= '0;
      opnd_q  <= '0;
      isDiv_q <= 1'b0;
      negLo_q <= 1'b0;
      negHi_q <= 1'b0;
    end else if (load_i) begin
      isDiv_q <= isDiv;
      if (divZero_o) begin
        acc_q   <= {opA_i, {WIDTH{1'b1}}};
        opnd_q  <= '0;
        negLo_q <= 1'b0;
        negHi_q <= 1'b0;
      end else if (isDiv) begin
        acc_q   <= {{WIDTH{1'b0}}, magA};
        opnd_q  <= magB;
        negLo_q <= negRes;
        negHi_q <= negRem;
      end else begin
        acc_q   <= {{WIDTH{1'b0}}, magB};
        opnd_q  <= magA;
        negLo_q <= negRes;
        negHi_q <= 1'b0;
      end
    end else if (step_i) begin
      acc_q <= acc_d;
    end
  end

  assign prod    = negLo_q ? -acc_q : acc_q;
  assign resLo_o = isDiv_q ? (negLo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0])
                           : prod[WIDTH-1:0];
  assign resHi_o = isDiv_q ? (negHi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH])
                           : prod[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO registers: sequencing FSM, HI/LO storage,
// pipeline stall generation and the MFHI/MFLO read mux.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITERS = WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] ALU_A,
  input  logic [WIDTH-1:0] ALU_B,
  input  logic             ReadReq,
  input  logic             HiLoSel,
  output logic [WIDTH-1:0] HiLoOut,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic             DivByZero
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  mdState_e         state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dbz_q, zeroPend_q;

  logic             load, divZero;
  logic [WIDTH-1:0] resHi, resLo;

  assign load = (state_q == ST_IDLE) && Start && !MDOp[2];

  mult_div_unit_core #(.WIDTH(WIDTH)) u_core (
    .clk_i     (Clk),
    .reset_i   (Reset),
    .load_i    (load),
    .step_i    (state_q == ST_CALC),
    .op_i      (MDOp),
    .opA_i     (ALU_A),
    .opB_i     (ALU_B),
    .divZero_o (divZero),
    .resHi_o   (resHi),
    .resLo_o   (resLo)
  );

  // Start is only honoured in IDLE; while busy the stall keeps it upstream.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      zeroPend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (Start) begin
            case (MDOp)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                dbz_q      <= 1'b0;
                cnt_q      <= '0;
                zeroPend_q <= divZero;
                state_q    <= divZero ? ST_FIX : ST_CALC;
              end
              MD_MTHI: hi_q <= ALU_A;
              MD_MTLO: lo_q <= ALU_A;
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITERS - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q    <= resHi;
          lo_q    <= resLo;
          done_q  <= 1'b1;
          dbz_q   <= zeroPend_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Stall     = Busy & (Start | ReadReq);
  assign HiLoOut   = HiLoSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push expected HI/LO
// results, an independent monitor pops and compares them on every Done pulse.
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Reset, Start, ReadReq, HiLoSel;
  logic        monSel, stimSel;
  logic [2:0]  MDOp;
  logic [31:0] ALU_A, ALU_B, HiLoOut;
  logic        Busy, Done, Stall, DivByZero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    string       name;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   fails  = 0;
  int   doneAt, busyCnt;

  assign HiLoSel = monSel | stimSel;

  mult_div_unit dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .MDOp      (MDOp),
    .ALU_A     (ALU_A),
    .ALU_B     (ALU_B),
    .ReadReq   (ReadReq),
    .HiLoSel   (HiLoSel),
    .HiLoOut   (HiLoOut),
    .Busy      (Busy),
    .Done      (Done),
    .Stall     (Stall),
    .DivByZero (DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expectResult(input string name, input logic [31:0] hi, input logic [31:0] lo, input logic dbz);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dbz = dbz; e.name = name;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge Clk); #1;
    Start = 1'b1; MDOp = op; ALU_A = a; ALU_B = b;
    @(posedge Clk); #1;
    Start = 1'b0; ALU_A = $urandom; ALU_B = $urandom;
  endtask

  // Counts cycles after the accepting edge; optionally pokes Start/ReadReq mid-operation.
  task automatic waitDone(input int injStart, input int injRead, output int doneK, output int busyK);
    doneK = -1;
    busyK = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge Clk);
      if (Busy) busyK++;
      if (Done) begin
        doneK = k;
        break;
      end
      if (k == injStart + 1) Start = 1'b0;
      if (k == injStart) begin
        Start = 1'b1; MDOp = 3'b011; ALU_A = 32'd999; ALU_B = 32'd3;
        #1 checkOutput("stall on Start while busy", {31'b0, Stall}, 32'd1);
      end
      if (k == injRead) begin
        ReadReq = 1'b1;
        #1 checkOutput("stall on ReadReq while busy", {31'b0, Stall}, 32'd1);
        ReadReq = 1'b0;
      end
    end
  endtask

  initial begin
    exp_t        e;
    logic [31:0] loV, hiV;
    monSel = 1'b0;
    forever begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        if (sbQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected Done: got Done=1, expected no pending result");
        end else begin
          e = sbQ.pop_front();
          loV = HiLoOut;
          monSel = 1'b1;
          #1 hiV = HiLoOut;
          monSel = 1'b0;
          checkOutput({e.name, " LO"}, loV, e.lo);
          checkOutput({e.name, " HI"}, hiV, e.hi);
          checkOutput({e.name, " DivByZero"}, {31'b0, DivByZero}, {31'b0, e.dbz});
        end
      end
    end
  end

  initial begin
    #100000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit sawDone;
    Reset = 1'b1; Start = 1'b0; ReadReq = 1'b0; stimSel = 1'b0;
    MDOp = 3'b000; ALU_A = '0; ALU_B = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    @(negedge Clk);
    checkOutput("reset Busy", {31'b0, Busy}, 32'd0);
    checkOutput("reset Done", {31'b0, Done}, 32'd0);
    checkOutput("reset DivByZero", {31'b0, DivByZero}, 32'd0);
    checkOutput("reset LO", HiLoOut, 32'd0);
    stimSel = 1'b1;
    #1 checkOutput("reset HI", HiLoOut, 32'd0);
    stimSel = 1'b0;

    // Reset and Start on the same edge
    @(posedge Clk); #1;
    Reset = 1'b1; Start = 1'b1; MDOp = 3'b001; ALU_A = 32'd3; ALU_B = 32'd3;
    @(posedge Clk); #1;
    Reset = 1'b0; Start = 1'b0;
    @(negedge Clk);
    checkOutput("reset beats start Busy", {31'b0, Busy}, 32'd0);

    expectResult("MULTU max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(-5, -5, doneAt, busyCnt);
    checkOutput("MULTU done latency", doneAt, 32'd34);
    checkOutput("MULTU busy cycles", busyCnt, 32'd33);

    expectResult("MULT -3*7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    applyStimulus(3'b000, 32'hFFFF_FFFD, 32'd7);
    waitDone(-5, -5, doneAt, busyCnt);
    checkOutput("MULT done latency", doneAt, 32'd34);

    expectResult("DIVU 100/7", 32'd2, 32'd14, 1'b0);
    applyStimulus(3'b011, 32'd100, 32'd7);
    waitDone(-5, -5, doneAt, busyCnt);
    checkOutput("DIVU done latency", doneAt, 32'd34);

    expectResult("DIV -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2);
    waitDone(-5, -5, doneAt, busyCnt);

    expectResult("DIV min/-1", 32'h0, 32'h8000_0000, 1'b0);
    applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(-5, -5, doneAt, busyCnt);

    expectResult("DIVU 5/0", 32'd5, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(3'b011, 32'd5, 32'd0);
    waitDone(-5, -5, doneAt, busyCnt);
    checkOutput("div-by-zero done latency", doneAt, 32'd2);
    checkOutput("div-by-zero busy cycles", busyCnt, 32'd1);
    checkOutput("div-by-zero flag at Done", {31'b0, DivByZero}, 32'd1);

    expectResult("MULTU 6*7 with stalls", 32'd0, 32'd42, 1'b0);
    applyStimulus(3'b001, 32'd6, 32'd7);
    checkOutput("DivByZero cleared on start", {31'b0, DivByZero}, 32'd0);
    waitDone(5, 10, doneAt, busyCnt);
    checkOutput("ignored restart latency", doneAt, 32'd34);

    @(negedge Clk);
    ReadReq = 1'b1;
    #1 checkOutput("ReadReq in IDLE no stall", {31'b0, Stall}, 32'd0);
    ReadReq = 1'b0;

    // Abort a MULT with Reset sampled at edge t+10
    applyStimulus(3'b000, 32'd5, 32'd9);
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checkOutput("abort Busy", {31'b0, Busy}, 32'd0);
    checkOutput("abort LO", HiLoOut, 32'd0);
    stimSel = 1'b1;
    #1 checkOutput("abort HI", HiLoOut, 32'd0);
    stimSel = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) sawDone = 1'b1;
    end
    checkOutput("abort no Done", {31'b0, sawDone}, 32'd0);

    @(posedge Clk); #1;
    Start = 1'b1; MDOp = 3'b101; ALU_A = 32'hCAFE_F00D;
    @(posedge Clk); #1;
    MDOp = 3'b100; ALU_A = 32'h1234_5678;
    @(posedge Clk); #1;
    Start = 1'b0; ReadReq = 1'b1; stimSel = 1'b1;
    @(negedge Clk);
    checkOutput("MTHI no Busy", {31'b0, Busy}, 32'd0);
    checkOutput("MFHI no stall", {31'b0, Stall}, 32'd0);
    checkOutput("MFHI after MTHI", HiLoOut, 32'h1234_5678);
    stimSel = 1'b0;
    #1 checkOutput("LO kept by MTHI", HiLoOut, 32'hCAFE_F00D);
    ReadReq = 1'b0;

    repeat (3) @(negedge Clk);
    checkOutput("scoreboard drained", sbQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
